// File: rtl/usb_rx_param_pkg.sv
// usb_rx_param_pkg: shared types and constants for the parametrised USB full-speed receiver.
package usb_rx_param_pkg;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010,
        PID_STALL = 4'b1110
    } pid_t;

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_PID, S_BODY, S_EOP, S_DONE, S_ERR} rx_state_t;

    localparam logic [4:0]  CRC5_POLY  = 5'h05;
    localparam logic [4:0]  CRC5_RES   = 5'b01100;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_RES  = 16'h800D;
    localparam logic [7:0]  SYNC_BYTE  = 8'h80;

    // Line states as {dplus, dminus}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    function automatic logic pid_ok(input logic [7:0] b);
        return (b[3:0] == ~b[7:4]) &&
               (b[3:0] inside {PID_OUT, PID_IN, PID_DATA0, PID_DATA1, PID_ACK, PID_NAK, PID_STALL});
    endfunction

    function automatic logic [4:0] crc5_next(input logic [4:0] c, input logic b);
        return {c[3:0], 1'b0} ^ ((b ^ c[4]) ? CRC5_POLY : 5'd0);
    endfunction

    function automatic logic [15:0] crc16_next(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((b ^ c[15]) ? CRC16_POLY : 16'd0);
    endfunction

endpackage

// File: rtl/usb_rx_param_bit_decoder.sv
// usb_rx_param_bit_decoder: line sync, bit-timing recovery, NRZI decode and bit unstuffing.
module usb_rx_param_bit_decoder
    import usb_rx_param_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk_i,
    input  logic n_rst_i,
    input  logic dplus_i,
    input  logic dminus_i,
    input  logic clr_i,
    output logic strobe_o,
    output logic fall_o,
    output logic bit_valid_o,
    output logic bit_val_o,
    output logic se0_o,
    output logic j_o,
    output logic stuff_err_o
);
    localparam int TW = $clog2(CLKS_PER_BIT);

    logic [1:0]    dp_q, dm_q;
    logic          dp_prev_q, lvl_q, lvl_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [2:0]    ones_q, ones_d;
    logic          dp_edge, line_se0, drop;

    assign dp_edge     = dp_q[1] ^ dp_prev_q;
    assign fall_o      = dp_edge & ~dp_q[1];
    assign strobe_o    = tmr_q == TW'(CLKS_PER_BIT / 2);
    assign line_se0    = {dp_q[1], dm_q[1]} == LINE_SE0;
    assign se0_o       = strobe_o & line_se0;
    assign j_o         = strobe_o & ({dp_q[1], dm_q[1]} == LINE_J);
    assign bit_val_o   = dp_q[1] == lvl_q;
    assign drop        = ones_q == 3'd6;
    assign bit_valid_o = strobe_o & ~line_se0 & ~drop;
    assign stuff_err_o = strobe_o & ~line_se0 & drop & bit_val_o;

    always_comb begin
        tmr_d  = (dp_edge || tmr_q == TW'(CLKS_PER_BIT - 1)) ? '0 : tmr_q + TW'(1);
        lvl_d  = strobe_o ? dp_q[1] : lvl_q;
        ones_d = clr_i ? 3'd0 :
                 (strobe_o && !line_se0) ? ((drop || !bit_val_o) ? 3'd0 : ones_q + 3'd1) : ones_q;
    end

    // Idle line is J, so history resets to dplus=1, dminus=0
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            dp_q      <= 2'b11;
            dm_q      <= 2'b00;
            dp_prev_q <= 1'b1;
            lvl_q     <= 1'b1;
            tmr_q     <= '0;
            ones_q    <= '0;
        end else begin
            dp_q      <= {dp_q[0], dplus_i};
            dm_q      <= {dm_q[0], dminus_i};
            dp_prev_q <= dp_q[1];
            lvl_q     <= lvl_d;
            tmr_q     <= tmr_d;
            ones_q    <= ones_d;
        end
    end

endmodule

// File: rtl/usb_rx_param.sv
// usb_rx_param: USB full-speed packet receiver with PID decode, CRC check, CRC strip and FIFO push.
module usb_rx_param
    import usb_rx_param_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 8,
    parameter int MAX_DATA_BYTES = 64,
    parameter int BUF_DEPTH      = 64,
    parameter int CHECK_CRC      = 1,
    localparam int OCC_W         = $clog2(BUF_DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             n_rst_i,
    input  logic             dplus_i,
    input  logic             dminus_i,
    input  logic [OCC_W-1:0] buffer_occupancy_i,
    output logic [7:0]       rx_packet_data_o,
    output logic             store_rx_packet_data_o,
    output logic             flush_o,
    output logic             rx_error_o,
    output logic             rx_transfer_active_o,
    output logic             rx_data_ready_o,
    output logic [3:0]       rx_packet_o
);
    localparam int NB_W = $clog2(MAX_DATA_BYTES + 3);

    logic strobe, fall, bit_valid, bit_val, se0, line_j, stuff_err, clr;

    usb_rx_param_bit_decoder #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_dec (
        .clk_i       (clk_i),
        .n_rst_i     (n_rst_i),
        .dplus_i     (dplus_i),
        .dminus_i    (dminus_i),
        .clr_i       (clr),
        .strobe_o    (strobe),
        .fall_o      (fall),
        .bit_valid_o (bit_valid),
        .bit_val_o   (bit_val),
        .se0_o       (se0),
        .j_o         (line_j),
        .stuff_err_o (stuff_err)
    );

    rx_state_t        state_q, state_d;
    logic [7:0]       shift_q, shift_d, d0_q, d0_d, d1_q, d1_d, data_q, data_d;
    logic [2:0]       bcnt_q, bcnt_d;
    logic [3:0]       pid_q, pid_d, pkt_q, pkt_d, jcnt_q, jcnt_d;
    logic [15:0]      crc_q, crc_d;
    logic [NB_W-1:0]  nb_q, nb_d;
    logic [1:0]       fill_q, fill_d;
    logic             eop_q, eop_d, store_q, store_d, flush_q, flush_d;
    logic             err_q, err_d, act_q, act_d, rdy_q, rdy_d;
    logic [7:0]       shift_nx;
    logic             byte_done, is_tok, is_data, crc_ok, body_ok;

    assign shift_nx  = {bit_val, shift_q[7:1]};
    assign byte_done = bit_valid && bcnt_q == 3'd7;
    assign is_tok    = pid_q[1:0] == 2'b01;
    assign is_data   = pid_q[1:0] == 2'b11;
    assign crc_ok    = CHECK_CRC == 0 || (is_tok ? crc_q[4:0] == CRC5_RES : crc_q == CRC16_RES);
    assign body_ok   = bcnt_q == 3'd0 && crc_ok && (is_tok ? nb_q == NB_W'(2) : nb_q >= NB_W'(2));

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcnt_d  = bcnt_q;
        pid_d   = pid_q;
        crc_d   = crc_q;
        nb_d    = nb_q;
        d0_d    = d0_q;
        d1_d    = d1_q;
        fill_d  = fill_q;
        eop_d   = eop_q;
        jcnt_d  = jcnt_q;
        data_d  = data_q;
        store_d = 1'b0;
        flush_d = 1'b0;
        err_d   = err_q;
        act_d   = act_q;
        rdy_d   = 1'b0;
        pkt_d   = pkt_q;
        clr     = 1'b0;
        if (bit_valid) begin
            shift_d = shift_nx;
            bcnt_d  = bcnt_q + 3'd1;
        end
        case (state_q)
            S_IDLE: begin
                clr    = 1'b1;
                bcnt_d = 3'd0;
                if (fall) begin
                    state_d = S_SYNC;
                    err_d   = 1'b0;
                    act_d   = 1'b1;
                end
            end
            S_SYNC: begin
                if (se0 || stuff_err) state_d = S_ERR;
                else if (byte_done) begin
                    clr     = 1'b1;
                    state_d = shift_nx == SYNC_BYTE ? S_PID : S_ERR;
                end
            end
            S_PID: begin
                if (se0 || stuff_err) state_d = S_ERR;
                else if (byte_done) begin
                    if (pid_ok(shift_nx)) begin
                        pid_d   = shift_nx[3:0];
                        crc_d   = '1;
                        nb_d    = '0;
                        fill_d  = 2'd0;
                        eop_d   = 1'b0;
                        state_d = shift_nx[1:0] == 2'b10 ? S_EOP : S_BODY;
                        flush_d = shift_nx[1:0] == 2'b11 && buffer_occupancy_i != '0;
                    end else state_d = S_ERR;
                end
            end
            S_BODY: begin
                if (stuff_err) state_d = S_ERR;
                else if (se0) begin
                    state_d = body_ok ? S_EOP : S_ERR;
                    eop_d   = 1'b1;
                end else if (bit_valid) begin
                    crc_d = is_tok ? {11'd0, crc5_next(crc_q[4:0], bit_val)} : crc16_next(crc_q, bit_val);
                    if (byte_done) begin
                        nb_d = nb_q + NB_W'(1);
                        if (is_tok ? nb_q == NB_W'(2) : nb_q == NB_W'(MAX_DATA_BYTES + 2)) state_d = S_ERR;
                        else if (is_data) begin
                            // Two-byte delay line: whatever is left in it at EOP is the CRC16
                            d1_d   = shift_nx;
                            d0_d   = d1_q;
                            fill_d = fill_q == 2'd2 ? 2'd2 : fill_q + 2'd1;
                            if (fill_q == 2'd2) begin
                                if (buffer_occupancy_i == OCC_W'(BUF_DEPTH)) state_d = S_ERR;
                                else begin
                                    store_d = 1'b1;
                                    data_d  = d0_q;
                                end
                            end
                        end
                    end
                end
            end
            S_EOP: begin
                if (strobe) begin
                    if (se0) eop_d = 1'b1;
                    else state_d = (eop_q && line_j) ? S_DONE : S_ERR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                act_d   = 1'b0;
                pkt_d   = pid_q;
                rdy_d   = is_data;
            end
            S_ERR: begin
                act_d = 1'b0;
                if (jcnt_q == 4'd8) state_d = S_IDLE;
                else if (strobe) jcnt_d = line_j ? jcnt_q + 4'd1 : 4'd0;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_ERR && state_q != S_ERR) begin
            err_d  = 1'b1;
            jcnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            bcnt_q  <= '0;
            pid_q   <= '0;
            crc_q   <= '1;
            nb_q    <= '0;
            d0_q    <= '0;
            d1_q    <= '0;
            fill_q  <= '0;
            eop_q   <= 1'b0;
            jcnt_q  <= '0;
            data_q  <= '0;
            store_q <= 1'b0;
            flush_q <= 1'b0;
            err_q   <= 1'b0;
            act_q   <= 1'b0;
            rdy_q   <= 1'b0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcnt_q  <= bcnt_d;
            pid_q   <= pid_d;
            crc_q   <= crc_d;
            nb_q    <= nb_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
            fill_q  <= fill_d;
            eop_q   <= eop_d;
            jcnt_q  <= jcnt_d;
            data_q  <= data_d;
            store_q <= store_d;
            flush_q <= flush_d;
            err_q   <= err_d;
            act_q   <= act_d;
            rdy_q   <= rdy_d;
            pkt_q   <= pkt_d;
        end
    end

    assign rx_packet_data_o       = data_q;
    assign store_rx_packet_data_o = store_q;
    assign flush_o                = flush_q;
    assign rx_error_o             = err_q;
    assign rx_transfer_active_o   = act_q;
    assign rx_data_ready_o        = rdy_q;
    assign rx_packet_o            = pkt_q;

endmodule

// File: tb/tb_usb_rx_param.sv
// tb_usb_rx_param: directed packets on D+/D-, expected FIFO events scoreboarded against a monitor.
module tb_usb_rx_param;
    logic       clk = 1'b0, n_rst = 1'b0, dp = 1'b1, dm = 1'b0;
    logic [6:0] occ = '0;
    logic [7:0] data;
    logic       store, flush, err, act, rdy;
    logic [3:0] pkt;

    int errors = 0, checks = 0;
    logic [11:0] exp_q[$];
    logic        bits[$];
    logic [7:0]  pl[$];
    bit          stuff_en = 1'b1;

    always #5 clk = ~clk;

    usb_rx_param dut (
        .clk_i                  (clk),
        .n_rst_i                (n_rst),
        .dplus_i                (dp),
        .dminus_i               (dm),
        .buffer_occupancy_i     (occ),
        .rx_packet_data_o       (data),
        .store_rx_packet_data_o (store),
        .flush_o                (flush),
        .rx_error_o             (err),
        .rx_transfer_active_o   (act),
        .rx_data_ready_o        (rdy),
        .rx_packet_o            (pkt)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // Event codes: 1=flush, 2=store(byte), 3=ready(pid)
    task automatic mon(input string nm, input logic [11:0] got);
        logic [11:0] want;
        want = exp_q.size() == 0 ? 12'hfff : exp_q.pop_front();
        chk(nm, got, want);
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            if (flush) mon("flush_evt", 12'h100);
            if (store) mon("store_evt", {4'h2, data});
            if (rdy)   mon("ready_evt", {8'h30, pkt});
        end
    end

    task automatic drive(input logic p, input logic m);
        #1;
        dp = p;
        dm = m;
        repeat (8) @(posedge clk);
    endtask

    task automatic add_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    endtask

    task automatic data_pkt(input logic [3:0] pid, input bit flip);
        logic [15:0] c;
        c = 16'hffff;
        bits.delete();
        add_byte(8'h80);
        add_byte({~pid, pid});
        foreach (pl[k]) begin
            add_byte(pl[k]);
            for (int i = 0; i < 8; i++)
                c = {c[14:0], 1'b0} ^ ((pl[k][i] ^ c[15]) ? 16'h8005 : 16'h0000);
        end
        c = ~c;
        for (int i = 15; i >= 0; i--) bits.push_back(c[i]);
        if (flip) bits[bits.size() - 3] = ~bits[bits.size() - 3];
    endtask

    // Stuffs (from the PID on), NRZI-encodes and drives; stops early after abort_at line bits
    task automatic send(input int abort_at);
        logic lvl;
        logic q[$];
        int   ones;
        lvl  = 1'b1;
        ones = 0;
        for (int i = 0; i < bits.size(); i++) begin
            q.push_back(bits[i]);
            if (i >= 8 && stuff_en) begin
                ones = bits[i] ? ones + 1 : 0;
                if (ones == 6) begin
                    q.push_back(1'b0);
                    ones = 0;
                end
            end
        end
        for (int i = 0; i < q.size(); i++) begin
            if (!q[i]) lvl = ~lvl;
            drive(lvl, ~lvl);
            if (i + 1 == abort_at) return;
        end
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        for (int i = 0; i < 13; i++) drive(1'b1, 1'b0);
    endtask

    task automatic expect_end(input string nm, input logic e, input logic [3:0] p);
        @(negedge clk);
        chk({nm, "_pending"}, exp_q.size(), 0);
        exp_q.delete();
        chk({nm, "_err"}, err, e);
        chk({nm, "_pid"}, pkt, p);
        chk({nm, "_active"}, act, 1'b0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_data"}, data, 8'h00);
        chk({nm, "_store"}, store, 1'b0);
        chk({nm, "_flush"}, flush, 1'b0);
        chk({nm, "_err"}, err, 1'b0);
        chk({nm, "_active"}, act, 1'b0);
        chk({nm, "_ready"}, rdy, 1'b0);
        chk({nm, "_pid"}, pkt, 4'h0);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        chk_all_zero("reset");
        n_rst = 1'b1;
        for (int i = 0; i < 12; i++) drive(1'b1, 1'b0);

        bits.delete(); add_byte(8'h80); add_byte(8'hD2);
        send(0);
        expect_end("ack", 1'b0, 4'h2);

        pl = {8'h00, 8'h01}; occ = 7'd0;
        exp_q = {12'h200, 12'h201, 12'h303};
        data_pkt(4'h3, 1'b0); send(0);
        expect_end("data0_2b", 1'b0, 4'h3);

        pl = {8'hFF, 8'hFF, 8'hFF, 8'hFF}; occ = 7'd5;
        exp_q = {12'h100, 12'h2FF, 12'h2FF, 12'h2FF, 12'h2FF, 12'h30B};
        data_pkt(4'hB, 1'b0); send(0);
        expect_end("data1_ff", 1'b0, 4'hB);

        pl = {8'hA5}; occ = 7'd0;
        exp_q = {12'h2A5};
        data_pkt(4'h3, 1'b1); send(0);
        expect_end("crc_flip", 1'b1, 4'hB);

        bits.delete(); add_byte(8'h80); add_byte(8'hE1); add_byte(8'h00); add_byte(8'h10);
        send(0);
        expect_end("out_tok", 1'b0, 4'h1);

        bits.delete(); add_byte(8'h80); add_byte(8'h11);
        send(0);
        expect_end("bad_pid", 1'b1, 4'h1);

        pl.delete();
        exp_q = {12'h30B};
        data_pkt(4'hB, 1'b0); send(0);
        expect_end("zero_len", 1'b0, 4'hB);

        stuff_en = 1'b0;
        pl = {8'h7F};
        data_pkt(4'h3, 1'b0); send(0);
        stuff_en = 1'b1;
        expect_end("seven_ones", 1'b1, 4'hB);

        pl = {8'h01, 8'h02, 8'h03}; occ = 7'd64;
        exp_q = {12'h100};
        data_pkt(4'h3, 1'b0); send(0);
        occ = 7'd0;
        expect_end("overflow", 1'b1, 4'hB);

        pl.delete();
        for (int i = 0; i < 64; i++) begin
            pl.push_back(8'(i));
            exp_q.push_back({4'h2, 8'(i)});
        end
        exp_q.push_back(12'h303);
        data_pkt(4'h3, 1'b0); send(0);
        expect_end("max_payload", 1'b0, 4'h3);

        pl.push_back(8'h40);
        for (int i = 0; i < 64; i++) exp_q.push_back({4'h2, 8'(i)});
        data_pkt(4'hB, 1'b0); send(0);
        expect_end("too_long", 1'b1, 4'h3);

        pl = {8'h11, 8'h22, 8'h33, 8'h44};
        data_pkt(4'h3, 1'b0); send(36);
        @(negedge clk);
        chk("midpkt_active", act, 1'b1);
        dp = 1'b1; dm = 1'b0; n_rst = 1'b0;
        #2;
        chk_all_zero("midpkt_reset");
        chk("midpkt_pending", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 12; i++) drive(1'b1, 1'b0);
        bits.delete(); add_byte(8'h80); add_byte(8'hD2);
        send(0);
        expect_end("after_reset", 1'b0, 4'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
